// File: rtl/rle_decoder_8_pkg.sv
// Shared constants and types for the JPEG RLE decoder slice.
// Symbol packing matches the encoder array entries: {run, val}.
package rle_decoder_8_pkg;

  localparam int COEF_W   = 8;
  localparam int RUN_W    = 6;
  localparam int BLOCK_SZ = 64;
  localparam int LINE_SZ  = 8;
  localparam int POS_W    = 6;
  localparam int COL_W    = 3;
  localparam int ROW_W    = 3;
  localparam int LINE_W   = LINE_SZ * COEF_W;
  localparam int SYM_W    = RUN_W + COEF_W;

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(BLOCK_SZ - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_SZ - 1);

  typedef struct packed {
    logic [RUN_W-1:0]  run;
    logic [COEF_W-1:0] val;
  } sym_t;

  typedef enum logic [2:0] {
    ACT_IDLE,
    ACT_ZRUN,
    ACT_VAL,
    ACT_EOB,
    ACT_SYM
  } act_e;

  function automatic logic [RUN_W-1:0] room(
    input logic [POS_W-1:0] pos
  );
    return LAST_POS - pos;
  endfunction

endpackage

// File: rtl/rle_decoder_8_if.sv
// Symbol input and line output handshake bundles.
// Master drives valid and payload, slave drives ready.
interface rle_sym_if;
  import rle_decoder_8_pkg::*;

  logic              sym_valid;
  logic              sym_ready;
  logic [RUN_W-1:0]  sym_run;
  logic [COEF_W-1:0] sym_val;
  logic              sym_eob;

  modport master (
    output sym_valid,
    output sym_run,
    output sym_val,
    output sym_eob,
    input  sym_ready
  );

  modport slave (
    input  sym_valid,
    input  sym_run,
    input  sym_val,
    input  sym_eob,
    output sym_ready
  );
endinterface

interface rle_row_if;
  import rle_decoder_8_pkg::*;

  logic              row_valid;
  logic              row_ready;
  logic [LINE_W-1:0] row_data;
  logic [ROW_W-1:0]  row_idx;
  logic              row_last;

  modport master (
    output row_valid,
    output row_data,
    output row_idx,
    output row_last,
    input  row_ready
  );

  modport slave (
    input  row_valid,
    input  row_data,
    input  row_idx,
    input  row_last,
    output row_ready
  );
endinterface

// File: rtl/rle_decoder_8_line_packer.sv
// Collects coefficients into an 8-wide line buffer and
// publishes each completed line on a valid/ready port.
module rle_decoder_8_line_packer
  import rle_decoder_8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr,
  input  logic [COL_W-1:0]  i_col,
  input  logic [ROW_W-1:0]  i_row,
  input  logic [COEF_W-1:0] i_data,
  rle_row_if.master         row
);

  logic [LINE_W-1:0] r_lbuf;
  logic              r_valid;
  logic [LINE_W-1:0] r_data;
  logic [ROW_W-1:0]  r_idx;
  logic              r_last;

  logic [LINE_W-1:0] w_line;
  logic              w_done;

  always_comb begin
    w_line = r_lbuf;
    w_line[int'(i_col)*COEF_W +: COEF_W] = i_data;
  end

  assign w_done = i_wr & (i_col == LAST_COL);

  // Writes only arrive when the output is free or draining,
  // so a completing line never clobbers an unaccepted one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lbuf  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
    end else begin
      if (i_wr) begin
        if (w_done) r_lbuf <= '0;
        else        r_lbuf <= w_line;
      end
      if (w_done) begin
        r_valid <= 1'b1;
        r_data  <= w_line;
        r_idx   <= i_row;
        r_last  <= (i_row == ROW_W'(LINE_SZ - 1));
      end else if (r_valid && row.row_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign row.row_valid = r_valid;
  assign row.row_data  = r_data;
  assign row.row_idx   = r_idx;
  assign row.row_last  = r_last;

endmodule

// File: rtl/rle_decoder_8.sv
// RLE symbol decoder: expands (run, value) and EOB symbols
// into 64-coefficient blocks emitted as eight 8-wide lines.
module rle_decoder_8
  import rle_decoder_8_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  rle_sym_if.slave  sym,
  rle_row_if.master row,
  output logic      err
);

  logic [POS_W-1:0]  r_pos;
  logic [RUN_W-1:0]  r_zrun;
  logic              r_vpend;
  logic [COEF_W-1:0] r_vreg;
  logic              r_eob;
  logic              r_err;

  logic [POS_W-1:0]  w_pos;
  logic [RUN_W-1:0]  w_zrun;
  logic              w_vpend;
  logic [COEF_W-1:0] w_vreg;
  logic              w_eob;
  logic              w_err;

  logic              w_stall;
  logic              w_ready;
  logic              w_wr;
  logic [COEF_W-1:0] w_wdata;
  logic [RUN_W-1:0]  w_room;
  act_e              w_act;

  assign w_stall = row.row_valid & ~row.row_ready;
  assign w_room  = room(r_pos);

  // Ready is held low during reset so every output reads 0.
  assign w_ready = reset & ~w_stall & (r_zrun == '0)
                 & ~r_vpend & ~r_eob;

  assign sym.sym_ready = w_ready;
  assign err           = r_err;

  always_comb begin
    w_act = ACT_IDLE;
    if (!w_stall) begin
      if (r_zrun != '0)                w_act = ACT_ZRUN;
      else if (r_vpend)                w_act = ACT_VAL;
      else if (r_eob)                  w_act = ACT_EOB;
      else if (sym.sym_valid & w_ready) w_act = ACT_SYM;
    end
  end

  always_comb begin
    w_pos   = r_pos;
    w_zrun  = r_zrun;
    w_vpend = r_vpend;
    w_vreg  = r_vreg;
    w_eob   = r_eob;
    w_err   = r_err;
    w_wr    = 1'b0;
    w_wdata = '0;
    unique case (w_act)
      ACT_ZRUN: begin
        w_wr   = 1'b1;
        w_zrun = r_zrun - RUN_W'(1);
      end
      ACT_VAL: begin
        w_wr    = 1'b1;
        w_wdata = r_vreg;
        w_vpend = 1'b0;
      end
      ACT_EOB: w_wr = 1'b1;
      ACT_SYM: begin
        w_wr = 1'b1;
        unique case (1'b1)
          sym.sym_eob: w_eob = 1'b1;
          (!sym.sym_eob && sym.sym_run == '0):
            w_wdata = sym.sym_val;
          (!sym.sym_eob && sym.sym_run > w_room): begin
            // Run past block end: zero-fill, drop the value.
            w_err   = 1'b1;
            w_zrun  = w_room;
            w_vpend = 1'b0;
          end
          default: begin
            w_zrun  = sym.sym_run - RUN_W'(1);
            w_vreg  = sym.sym_val;
            w_vpend = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
    if (w_wr) begin
      w_pos = r_pos + POS_W'(1);
      if (r_pos == LAST_POS) begin
        w_eob   = 1'b0;
        w_zrun  = '0;
        w_vpend = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pos   <= '0;
      r_zrun  <= '0;
      r_vpend <= 1'b0;
      r_vreg  <= '0;
      r_eob   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_pos   <= w_pos;
      r_zrun  <= w_zrun;
      r_vpend <= w_vpend;
      r_vreg  <= w_vreg;
      r_eob   <= w_eob;
      r_err   <= w_err;
    end
  end

  rle_decoder_8_line_packer u_packer (
    .clk    (clk),
    .rst_n  (reset),
    .i_wr   (w_wr),
    .i_col  (r_pos[COL_W-1:0]),
    .i_row  (r_pos[POS_W-1:COL_W]),
    .i_data (w_wdata),
    .row    (row)
  );

endmodule
